down_counter_4b: RTL and testbench

- Loadable countdown counter: the decrementing counterpart of the team's ripple-carry up-counter.
- Built structurally from a ripple-borrow subtractor chain of full-subtractor cells, which compute out − 1.
- A small FSM counts a loaded value down to zero and then pulses done.
- Used as a cycle/event timer alongside the up-counter.

---
 rtl/down_counter_4b_if.sv | 23 ++
 rtl/down_counter_4b.sv | 113 +++++++++++
 tb/tb_down_counter_4b.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/down_counter_4b_if.sv
// Control/status bundle for the loadable countdown timer: load/enable toward the
// counter, count/busy/done/borrow back to the requester.
interface down_counter_4b_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             borrow;

  modport master (
    output load, load_val, en,
    input  out, busy, done, borrow
  );

  modport slave (
    input  load, load_val, en,
    output out, busy, done, borrow
  );
endinterface

// File: rtl/down_counter_4b.sv
// Loadable countdown timer: ripple-borrow full-subtractor chain computes out-1, a
// 3-state FSM counts a loaded value to zero and pulses done. Define AUTO_RELOAD_EN
// to restart from the last loaded value instead of stopping at the terminal count.
module down_counter_4b #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  down_counter_4b_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   brw;

  // One full-subtractor cell: returns {borrow_out, diff} for a - b - bin.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  assign brw[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    assign {brw[i+1], dec[i]} = full_sub(cnt[i], 1'b0, brw[i]);
  end

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        // Load wins over en in every state; a zero load terminates immediately.
        cnt <= bus.load_val;
`ifdef AUTO_RELOAD_EN
        reload <= bus.load_val;
`endif
        if (bus.load_val != '0) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end else begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (bus.en) begin
              if (cnt == WIDTH'(1)) begin
`ifdef AUTO_RELOAD_EN
                if (reload != '0) begin
                  cnt    <= reload;
                  done_q <= 1'b1;
                end else begin
                  cnt    <= '0;
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end
`else
                cnt    <= '0;
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
`endif
              end else begin
                cnt <= dec;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out    = cnt;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.borrow = brw[WIDTH];

endmodule

// File: tb/tb_down_counter_4b.sv
// Directed plus randomized bench for down_counter_4b against a behavioural timer model.
module tb_down_counter_4b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  down_counter_4b_if #(.WIDTH(4)) ifc ();

  down_counter_4b #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference timer: a remaining-count, an active flag and the terminal pulse.
  int m_cnt    = 0;
  int m_reload = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;

  task automatic model_step(input bit r, input bit l, input int v, input bit e);
    bit nd;
    nd = 1'b0;
    if (r) begin
      m_cnt = 0; m_active = 1'b0; m_reload = 0;
    end else if (l) begin
      m_cnt = v; m_reload = v;
      if (v != 0) m_active = 1'b1;
      else begin m_active = 1'b0; nd = 1'b1; end
    end else if (m_active && e) begin
      if (m_cnt == 1) begin
        nd = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (m_reload != 0) m_cnt = m_reload;
        else begin m_cnt = 0; m_active = 1'b0; end
`else
        m_cnt = 0; m_active = 1'b0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    m_done = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit l, input logic [3:0] v, input bit e);
    rst = r; ifc.load = l; ifc.load_val = v; ifc.en = e;
    @(posedge clk);
    model_step(r, l, int'(v), e);
    #1;
    chk("out",    32'(ifc.out),    32'(m_cnt));
    chk("busy",   32'(ifc.busy),   32'(m_active));
    chk("done",   32'(ifc.done),   32'(m_done));
    chk("borrow", 32'(ifc.borrow), 32'(m_cnt == 0));
  endtask

  initial begin
    ifc.load = 1'b0; ifc.load_val = '0; ifc.en = 1'b0;

    // Reset held two cycles while load requests 9.
    tick(1, 1, 4'd9, 1);
    tick(1, 1, 4'd9, 1);
    chk("rst_out", 32'(ifc.out), 32'd0);
    chk("rst_borrow", 32'(ifc.borrow), 32'd1);

    // Basic count from 3.
    tick(0, 1, 4'd3, 0);
    chk("basic_load", 32'(ifc.out), 32'd3);
    tick(0, 0, 4'd0, 1);
    chk("basic_2", 32'(ifc.out), 32'd2);
    tick(0, 0, 4'd0, 1);
    chk("basic_1", 32'(ifc.out), 32'd1);
    tick(0, 0, 4'd0, 1);
`ifndef AUTO_RELOAD_EN
    chk("basic_0", 32'(ifc.out), 32'd0);
    chk("basic_done", 32'(ifc.done), 32'd1);
    chk("basic_busy", 32'(ifc.busy), 32'd0);
`endif
    tick(0, 0, 4'd0, 1);
`ifndef AUTO_RELOAD_EN
    chk("basic_done_low", 32'(ifc.done), 32'd0);
`endif

    // Hold pattern and load priority over en.
    tick(0, 1, 4'd5, 0);
    tick(0, 0, 4'd0, 1);
    tick(0, 0, 4'd0, 0);
    tick(0, 0, 4'd0, 0);
    chk("hold_4", 32'(ifc.out), 32'd4);
    tick(0, 0, 4'd0, 1);
    chk("hold_3", 32'(ifc.out), 32'd3);
    tick(0, 1, 4'd7, 1);
    chk("prio_7", 32'(ifc.out), 32'd7);

    // Zero load from IDLE (reset first to return to IDLE).
    tick(1, 0, 4'd0, 0);
    tick(0, 0, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    chk("zero_done", 32'(ifc.done), 32'd1);
    chk("zero_busy", 32'(ifc.busy), 32'd0);
    tick(0, 0, 4'd0, 0);
    chk("zero_done_low", 32'(ifc.done), 32'd0);
    tick(0, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    chk("zero_b2b_done", 32'(ifc.done), 32'd1);

    // Mid-count reset aborts with no done pulse.
    tick(0, 1, 4'd15, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 4'd0, 1);
    chk("mid_11", 32'(ifc.out), 32'd11);
    tick(1, 0, 4'd0, 1);
    chk("mid_rst_out", 32'(ifc.out), 32'd0);
    tick(0, 0, 4'd0, 1);
    tick(0, 0, 4'd0, 1);

`ifdef AUTO_RELOAD_EN
    // Auto-reload: 2,1,2,1,... with done on each reload and busy held.
    tick(0, 1, 4'd2, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 4'd0, 1);
      chk("ar_busy", 32'(ifc.busy), 32'd1);
      chk("ar_out", 32'(ifc.out), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("ar_done", 32'(ifc.done), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
`endif

    // Randomized traffic, biased toward small loads so terminals happen often.
    for (int i = 0; i < 400; i++) begin
      bit r, l, e;
      logic [3:0] v;
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      tick(r, l, v, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
